// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer
// Reads a block of consecutive RTC registers over the multiplexed
// address/data bus. For each register it runs four equal-length phases:
// an address write, a bus-idle gap, a data read and a second gap. The
// captured byte is presented with a one-cycle valid strobe.
// All bus outputs are registered and change together with the state.
module rtc_read_sequencer #(
  parameter int         NUM_REGS  = 6,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       init_done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic       ad_oe,
  output logic [7:0] ad_out,
  input  logic [7:0] ad_in,
  output logic [7:0] data_out,
  output logic [2:0] reg_index,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2,
    S_DONE
  } state_t;

  localparam logic [3:0] PHASE_LAST = 4'(PHASE_CYC - 1);
  localparam logic [2:0] INDEX_LAST = 3'(NUM_REGS - 1);

  state_t     r_state;
  logic [3:0] r_phase;
  logic [2:0] r_index;

  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad_n;
  logic       r_ad_oe;
  logic [7:0] r_ad_out;
  logic [7:0] r_data_out;
  logic [2:0] r_reg_index;
  logic       r_data_valid;
  logic       r_busy;
  logic       r_done;

  logic       w_phase_end;
  logic [2:0] w_index_inc;
  logic [7:0] w_next_addr;

  assign w_phase_end = (r_phase == PHASE_LAST);
  assign w_index_inc = r_index + 3'd1;
  // Address of the next register; the 8-bit add wraps past 8'hFF.
  assign w_next_addr = BASE_ADDR + {5'd0, w_index_inc};

  // Sequencer FSM: state, phase/index counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= 4'd0;
      r_index      <= 3'd0;
      r_cs_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_ad_n       <= 1'b1;
      r_ad_oe      <= 1'b0;
      r_ad_out     <= 8'd0;
      r_data_out   <= 8'd0;
      r_reg_index  <= 3'd0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Strobes default low; only set on the edge that starts their cycle.
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_phase <= 4'd0;
          if (start && init_done) begin
            r_state  <= S_ADDR;
            r_index  <= 3'd0;
            r_busy   <= 1'b1;
            r_cs_n   <= 1'b0;
            r_wr_n   <= 1'b0;
            r_ad_n   <= 1'b0;
            r_ad_oe  <= 1'b1;
            r_ad_out <= BASE_ADDR;
          end
        end
        S_ADDR: begin
          if (w_phase_end) begin
            r_state <= S_GAP1;
            r_phase <= 4'd0;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_ad_n  <= 1'b1;
            r_ad_oe <= 1'b0;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        S_GAP1: begin
          if (w_phase_end) begin
            r_state <= S_DATA;
            r_phase <= 4'd0;
            r_cs_n  <= 1'b0;
            r_rd_n  <= 1'b0;
            r_ad_n  <= 1'b1;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        S_DATA: begin
          if (w_phase_end) begin
            r_state      <= S_GAP2;
            r_phase      <= 4'd0;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_data_out   <= ad_in;
            r_reg_index  <= r_index;
            r_data_valid <= 1'b1;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        S_GAP2: begin
          if (w_phase_end) begin
            r_phase <= 4'd0;
            if (r_index == INDEX_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_ADDR;
              r_index  <= w_index_inc;
              r_cs_n   <= 1'b0;
              r_wr_n   <= 1'b0;
              r_ad_n   <= 1'b0;
              r_ad_oe  <= 1'b1;
              r_ad_out <= w_next_addr;
            end
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        S_DONE: begin
          // A start seen here is dropped, not queued.
          r_state <= S_IDLE;
          r_phase <= 4'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_phase <= 4'd0;
        end
      endcase
    end
  end

  assign cs_n       = r_cs_n;
  assign rd_n       = r_rd_n;
  assign wr_n       = r_wr_n;
  assign ad_n       = r_ad_n;
  assign ad_oe      = r_ad_oe;
  assign ad_out     = r_ad_out;
  assign data_out   = r_data_out;
  assign reg_index  = r_reg_index;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: a default instance and a small wrapping
// instance, each with a simple RTC bus model answering 8'h10 + address.
module tb_rtc_read_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i   [2];
  logic       start_i [2];
  logic       init_i  [2];
  logic       cs_n_o  [2];
  logic       rd_n_o  [2];
  logic       wr_n_o  [2];
  logic       ad_n_o  [2];
  logic       ad_oe_o [2];
  logic [7:0] ad_out_o[2];
  logic [7:0] ad_in_i [2];
  logic [7:0] data_o  [2];
  logic [2:0] idx_o   [2];
  logic       dv_o    [2];
  logic       busy_o  [2];
  logic       done_o  [2];

  rtc_read_sequencer dut0 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .init_done(init_i[0]),
    .cs_n(cs_n_o[0]), .rd_n(rd_n_o[0]), .wr_n(wr_n_o[0]), .ad_n(ad_n_o[0]),
    .ad_oe(ad_oe_o[0]), .ad_out(ad_out_o[0]), .ad_in(ad_in_i[0]),
    .data_out(data_o[0]), .reg_index(idx_o[0]), .data_valid(dv_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  rtc_read_sequencer #(.NUM_REGS(3), .BASE_ADDR(8'hFE), .PHASE_CYC(2)) dut1 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .init_done(init_i[1]),
    .cs_n(cs_n_o[1]), .rd_n(rd_n_o[1]), .wr_n(wr_n_o[1]), .ad_n(ad_n_o[1]),
    .ad_oe(ad_oe_o[1]), .ad_out(ad_out_o[1]), .ad_in(ad_in_i[1]),
    .data_out(data_o[1]), .reg_index(idx_o[1]), .data_valid(dv_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  int         P_A[2] = '{4, 2};
  int         N_A[2] = '{6, 3};
  logic [7:0] B_A[2] = '{8'h21, 8'hFE};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit cmp_en = 0;
  int start_cyc[2] = '{0, 0};

  // RTC bus model: latches the address cycle, answers 8'h10 + address.
  logic [7:0] lat[2] = '{8'h00, 8'h00};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (!cs_n_o[i] && !wr_n_o[i] && !ad_n_o[i] && ad_oe_o[i]) lat[i] <= ad_out_o[i];
  end
  assign ad_in_i[0] = 8'h10 + lat[0];
  assign ad_in_i[1] = 8'h10 + lat[1];

  always @(posedge clk) cyc = cyc + 1;

  // Model: t counts cycles since acceptance (0 = first address cycle).
  bit         m_act [2] = '{0, 0};
  int         m_t   [2] = '{0, 0};
  logic [7:0] m_data[2] = '{8'h00, 8'h00};
  logic [7:0] m_addr[2] = '{8'h00, 8'h00};
  logic [2:0] m_idx [2] = '{3'd0, 3'd0};
  int         mk, mr, mp, mn;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mp = P_A[i];
      mn = N_A[i];
      if (rst_i[i]) begin
        m_act[i] = 0; m_data[i] = 8'h00; m_addr[i] = 8'h00; m_idx[i] = 3'd0;
      end else if (!m_act[i]) begin
        if (start_i[i] && init_i[i]) begin
          m_act[i] = 1; m_t[i] = 0; m_addr[i] = B_A[i];
        end
      end else if (m_t[i] == 4 * mp * mn) begin
        m_act[i] = 0;
      end else begin
        mk = m_t[i] / (4 * mp);
        mr = m_t[i] % (4 * mp);
        if (mr == 3 * mp - 1) begin
          m_data[i] = 8'(8'h10 + B_A[i] + mk);
          m_idx[i]  = 3'(mk);
        end
        m_t[i] = m_t[i] + 1;
        if (m_t[i] < 4 * mp * mn && m_t[i] % (4 * mp) == 0)
          m_addr[i] = 8'(B_A[i] + m_t[i] / (4 * mp));
      end
    end
  end

  // Event logs of what the DUTs did, relative to the last accepted start.
  int         dv_t[2][$];
  logic [7:0] dv_d[2][$];
  logic [2:0] dv_x[2][$];
  int         done_t[2][$];
  logic [7:0] addr_l[2][$];
  logic       prev_wr[2] = '{1'b1, 1'b1};

  // Compare process: every cycle, every output of both instances.
  logic [26:0] ev, av;
  int          ep, er;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cmp_en) begin
        ev = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_addr[i], m_data[i], m_idx[i]};
        if (m_act[i]) begin
          if (m_t[i] == 4 * P_A[i] * N_A[i]) begin
            ev[20] = 1'b1;
          end else begin
            er = m_t[i] % (4 * P_A[i]);
            ep = er / P_A[i];
            ev[21] = 1'b1;
            if (ep == 0) begin ev[26] = 1'b0; ev[24] = 1'b0; ev[23] = 1'b0; ev[22] = 1'b1; end
            if (ep == 2) begin ev[26] = 1'b0; ev[25] = 1'b0; end
            if (er == 3 * P_A[i]) ev[19] = 1'b1;
          end
        end
        av = {cs_n_o[i], rd_n_o[i], wr_n_o[i], ad_n_o[i], ad_oe_o[i], busy_o[i], done_o[i],
              dv_o[i], ad_out_o[i], data_o[i], idx_o[i]};
        n_cmp++;
        if (av !== ev) begin
          n_fail++;
          $display("FAIL cycle_cmp inst=%0d cyc=%0d got={cs,rd,wr,ad,oe,busy,done,dv}=%b ad_out=%h data=%h idx=%0d required=%b ad_out=%h data=%h idx=%0d",
                   i, cyc, av[26:19], av[18:11], av[10:3], av[2:0],
                   ev[26:19], ev[18:11], ev[10:3], ev[2:0]);
        end
      end
      if (dv_o[i] === 1'b1) begin
        dv_t[i].push_back(cyc - start_cyc[i]);
        dv_d[i].push_back(data_o[i]);
        dv_x[i].push_back(idx_o[i]);
      end
      if (done_o[i] === 1'b1) done_t[i].push_back(cyc - start_cyc[i]);
      if (wr_n_o[i] === 1'b0 && prev_wr[i] === 1'b1) addr_l[i].push_back(ad_out_o[i]);
      prev_wr[i] = wr_n_o[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic clear_logs(input int i);
    dv_t[i].delete(); dv_d[i].delete(); dv_x[i].delete();
    done_t[i].delete(); addr_l[i].delete();
  endtask

  task automatic do_start(input int i);
    clear_logs(i);
    start_i[i] = 1'b1;
    tick(1);
    start_cyc[i] = cyc;
    start_i[i] = 1'b0;
  endtask

  task automatic check_dv(input string name, input int i, input int n,
                          input int te[8], input int de[8]);
    chk({name, "_dv_count"}, dv_t[i].size(), n);
    for (int j = 0; j < n && j < dv_t[i].size(); j++) begin
      $display("txn %s inst=%0d strobe %0d: cycle=%0d index=%0d data=%h", name, i, j,
               dv_t[i][j], dv_x[i][j], dv_d[i][j]);
      chk({name, "_dv_cycle"}, dv_t[i][j], te[j]);
      chk({name, "_dv_data"}, int'(dv_d[i][j]), de[j]);
      chk({name, "_dv_index"}, int'(dv_x[i][j]), j);
    end
  endtask

  task automatic check_done(input string name, input int i, input int n, input int t);
    chk({name, "_done_count"}, done_t[i].size(), n);
    if (n == 1 && done_t[i].size() == 1) chk({name, "_done_cycle"}, done_t[i][0], t);
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1'b1; start_i[i] = 1'b1; init_i[i] = 1'b1;
    end
    // Reset with start held high: reset dominates.
    tick(1);
    cmp_en = 1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1'b0; start_i[i] = 1'b0; init_i[i] = 1'b0;
    end
    tick(1);
    chk("reset_busy", int'(busy_o[0]), 0);
    chk("reset_cs_n", int'(cs_n_o[0]), 1);
    chk("reset_ad_out", int'(ad_out_o[0]), 0);
    $display("txn reset: busy=%0d cs_n=%0d", busy_o[0], cs_n_o[0]);

    // Start while init_done is low: nothing must happen.
    start_i[0] = 1'b1;
    tick(1);
    start_i[0] = 1'b0;
    cnt = 0;
    for (int j = 0; j < 200; j++) begin
      if (cs_n_o[0] == 1'b0 || busy_o[0] == 1'b1) cnt++;
      tick(1);
    end
    chk("gated_bus_activity", cnt, 0);
    $display("txn gated start: active cycles=%0d", cnt);

    // Full default read.
    init_i[0] = 1'b1;
    init_i[1] = 1'b1;
    do_start(0);
    chk("first_busy", int'(busy_o[0]), 1);
    chk("first_ad_out", int'(ad_out_o[0]), 'h21);
    chk("first_ad_n", int'(ad_n_o[0]), 0);
    chk("first_wr_n", int'(wr_n_o[0]), 0);
    tick(99);
    check_dv("full", 0, 6, '{12, 28, 44, 60, 76, 92, 0, 0},
             '{'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 0, 0});
    check_done("full", 0, 1, 96);
    chk("full_addr_count", addr_l[0].size(), 6);
    if (addr_l[0].size() == 6) chk("full_addr_last", int'(addr_l[0][5]), 'h26);

    // Start pulses during the sequence and on the done cycle are ignored.
    do_start(0);
    tick(10);
    start_i[0] = 1'b1;
    tick(1);
    start_i[0] = 1'b0;
    tick(85);
    start_i[0] = 1'b1;
    tick(1);
    start_i[0] = 1'b0;
    chk("ignored_idle97_busy", int'(busy_o[0]), 0);
    chk("ignored_idle97_cs_n", int'(cs_n_o[0]), 1);
    tick(1);
    chk("ignored_no_restart", int'(busy_o[0]), 0);
    tick(2);
    check_dv("ignored", 0, 6, '{12, 28, 44, 60, 76, 92, 0, 0},
             '{'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 0, 0});
    check_done("ignored", 0, 1, 96);

    // Reset during the data phase of register 2.
    do_start(0);
    tick(40);
    rst_i[0] = 1'b1;
    tick(1);
    chk("midrst_busy", int'(busy_o[0]), 0);
    chk("midrst_cs_n", int'(cs_n_o[0]), 1);
    chk("midrst_rd_n", int'(rd_n_o[0]), 1);
    chk("midrst_ad_oe", int'(ad_oe_o[0]), 0);
    rst_i[0] = 1'b0;
    tick(10);
    check_dv("midrst", 0, 2, '{12, 28, 0, 0, 0, 0, 0, 0},
             '{'h31, 'h32, 0, 0, 0, 0, 0, 0});
    check_done("midrst", 0, 0, 0);
    do_start(0);
    chk("restart_ad_out", int'(ad_out_o[0]), 'h21);
    tick(99);
    check_dv("restart", 0, 6, '{12, 28, 44, 60, 76, 92, 0, 0},
             '{'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 0, 0});
    check_done("restart", 0, 1, 96);

    // Small instance: address wrap through 8'hFF.
    do_start(1);
    tick(27);
    check_dv("wrap", 1, 3, '{6, 14, 22, 0, 0, 0, 0, 0},
             '{'h0E, 'h0F, 'h10, 0, 0, 0, 0, 0});
    check_done("wrap", 1, 1, 24);
    chk("wrap_addr_count", addr_l[1].size(), 3);
    if (addr_l[1].size() == 3) begin
      $display("txn wrap addresses: %h %h %h", addr_l[1][0], addr_l[1][1], addr_l[1][2]);
      chk("wrap_addr0", int'(addr_l[1][0]), 'hFE);
      chk("wrap_addr1", int'(addr_l[1][1]), 'hFF);
      chk("wrap_addr2", int'(addr_l[1][2]), 'h00);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
